// File: rtl/adain_feature_buffer.sv
// Feature-map buffer for the AdaIN core: fills a local RAM from a valid/ready stream,
// then replays it once per pass while holding N/ys/yb stable for the whole frame.
module adain_feature_buffer #(
    parameter int WIDTH_IN   = 48,
    parameter int N_MAX      = 256,
    parameter int NUM_PASSES = 3,
    localparam int WIDTH_N   = $clog2(N_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    input  logic [WIDTH_N-1:0]  cfg_n,
    input  logic [WIDTH_IN-1:0] cfg_ys,
    input  logic [WIDTH_IN-1:0] cfg_yb,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WIDTH_IN-1:0] s_data,
    input  logic                s_last,
    output logic [1:0]          core_start,
    output logic [WIDTH_N-1:0]  core_N,
    output logic [WIDTH_IN-1:0] core_in,
    output logic [WIDTH_IN-1:0] core_ys,
    output logic [WIDTH_IN-1:0] core_yb,
    input  logic [1:0]          core_done,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);

    localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [WIDTH_N-1:0] N_MAX_W   = WIDTH_N'(N_MAX);
    localparam logic [1:0]         LAST_PASS = 2'(NUM_PASSES);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_STREAM, S_WAIT} state_t;

    state_t               r_state, w_next;
    logic [WIDTH_N-1:0]   r_n, r_wcnt, r_rcnt;
    logic [WIDTH_IN-1:0]  r_ys, r_yb, r_core_in;
    logic [1:0]           r_pass;
    logic                 r_busy, r_err, r_frame_done;
    logic [WIDTH_IN-1:0]  r_mem [N_MAX];

    logic [WIDTH_N-1:0]   w_n_last;
    logic                 w_cfg_ok, w_beat, w_fill_end, w_rd_last, w_done_hit, w_rd_en;
    logic [AW-1:0]        w_raddr;

    assign w_n_last   = r_n - WIDTH_N'(1);
    assign w_cfg_ok   = (cfg_n != '0) && (cfg_n <= N_MAX_W);
    assign w_beat     = (r_state == S_FILL) && s_valid;
    assign w_fill_end = w_beat && (r_wcnt == w_n_last);
    assign w_rd_last  = (r_rcnt == w_n_last);
    assign w_done_hit = (r_state == S_WAIT) && (core_done == r_pass);
    // r_rcnt tracks the sample currently on core_in; the read in flight is the next one.
    assign w_rd_en    = (r_state == S_START) || ((r_state == S_STREAM) && !w_rd_last);
    assign w_raddr    = (r_state == S_START) ? '0 : AW'(r_rcnt + WIDTH_N'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cfg_valid && w_cfg_ok) w_next = S_FILL;
            S_FILL:   if (w_fill_end) w_next = S_START;
            S_START:  w_next = S_STREAM;
            S_STREAM: if (w_rd_last) w_next = S_WAIT;
            S_WAIT:   if (w_done_hit) w_next = (r_pass == LAST_PASS) ? S_IDLE : S_START;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        core_start = '0;
        if (r_state == S_FILL)  s_ready    = 1'b1;
        if (r_state == S_START) core_start = r_pass;
    end

    always_ff @(posedge clk) begin
        if (w_beat) r_mem[r_wcnt[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n          <= '0;
            r_ys         <= '0;
            r_yb         <= '0;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_pass       <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_core_in    <= '0;
        end else begin
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_rd_en) r_core_in <= r_mem[w_raddr];
            case (r_state)
                S_IDLE: if (cfg_valid) begin
                    if (!w_cfg_ok) begin
                        r_err <= 1'b1;
                    end else begin
                        r_n    <= cfg_n;
                        r_ys   <= cfg_ys;
                        r_yb   <= cfg_yb;
                        r_busy <= 1'b1;
                        r_pass <= 2'd1;
                        r_wcnt <= '0;
                    end
                end
                S_FILL: if (w_beat) begin
                    // s_last only flags errors; the fill always ends on beat n-1.
                    r_err  <= s_last != (r_wcnt == w_n_last);
                    r_wcnt <= w_fill_end ? '0 : r_wcnt + WIDTH_N'(1);
                end
                S_START:  r_rcnt <= '0;
                S_STREAM: if (!w_rd_last) r_rcnt <= r_rcnt + WIDTH_N'(1);
                S_WAIT: if (w_done_hit) begin
                    if (r_pass == LAST_PASS) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_pass <= r_pass + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_N     = r_n;
    assign core_ys    = r_ys;
    assign core_yb    = r_yb;
    assign core_in    = r_core_in;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_adain_feature_buffer.sv
// Directed bench for adain_feature_buffer: fill, three-pass replay, error pulses,
// handshake gaps, stray core_done codes, async abort and a full-depth frame.
module tb_adain_feature_buffer;

    localparam int W  = 48;
    localparam int NM = 256;
    localparam int WN = $clog2(NM + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic [WN-1:0] cfg_n;
    logic [W-1:0]  cfg_ys, cfg_yb;
    logic          s_valid, s_ready, s_last;
    logic [W-1:0]  s_data;
    logic [1:0]    core_start, core_done;
    logic [WN-1:0] core_N;
    logic [W-1:0]  core_in, core_ys, core_yb;
    logic          busy, frame_done, err;

    adain_feature_buffer #(.WIDTH_IN(W), .N_MAX(NM), .NUM_PASSES(3)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_n(cfg_n),
        .cfg_ys(cfg_ys), .cfg_yb(cfg_yb), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .core_start(core_start), .core_N(core_N),
        .core_in(core_in), .core_ys(core_ys), .core_yb(core_yb), .core_done(core_done),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_errp = 0;
    int unsigned n_fd = 0;
    logic [W-1:0] dat [NM];

    always @(negedge clk) begin
        if (err)        n_errp++;
        if (frame_done) n_fd++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int n, input logic [W-1:0] ys, input logic [W-1:0] yb);
        cfg_valid = 1'b1;
        cfg_n     = WN'(n);
        cfg_ys    = ys;
        cfg_yb    = yb;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Streams dat[0..n-1]; s_last on beat last_pos and optionally on beat n-1.
    task automatic fill(input int n, input int last_pos, input bit last_at_end, input bit toggle);
        int acc = 0;
        int cyc = 0;
        bit acc_now, exp_err;
        while (acc < n && cyc < 4 * n + 20) begin
            s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data  = dat[acc];
            s_last  = (acc == last_pos) || (last_at_end && acc == n - 1);
            acc_now = s_valid && s_ready;
            exp_err = s_last != (acc == n - 1);
            tick();
            if (acc_now) begin
                chk("fill_err", err, exp_err);
                acc++;
            end
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("fill_beats", acc, n);
        chk("ready_drop", s_ready, 1'b0);
    endtask

    task automatic passes(input int n, input int dly, input bit bad, input int abort_pass);
        for (int p = 1; p <= 3; p++) begin
            int cnt = 0;
            while (core_start == 2'b00 && cnt < 40) begin
                tick();
                cnt++;
            end
            chk("start_code", core_start, p);
            chk("core_N", core_N, n);
            for (int k = 0; k < n; k++) begin
                if (p == abort_pass && k == 3) return;
                tick();
                chk("core_in", core_in, dat[k]);
            end
            repeat (dly) tick();
            if (bad && p == 1) begin
                core_done = 2'b10;
                tick();
                core_done = 2'b00;
                chk("wrong_done", core_start, 2'b00);
                tick();
                chk("wrong_done_hold", core_start, 2'b00);
            end
            core_done = 2'(p);
            tick();
            core_done = 2'b00;
            if (p < 3) begin
                chk("restart", core_start, p + 1);
            end else begin
                chk("frame_done", frame_done, 1'b1);
                chk("busy_clear", busy, 1'b0);
                tick();
                chk("frame_done_pulse", frame_done, 1'b0);
            end
        end
    endtask

    initial begin
        int e0, f0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_ys = '0; cfg_yb = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; core_done = 2'b00;
        repeat (2) tick();
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", core_start, 2'b00);
        chk("rst_N", core_N, 0);
        chk("rst_in", core_in, 0);
        chk("rst_ys", core_ys, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        tick();

        // basic 4-sample frame
        for (int i = 0; i < 4; i++) dat[i] = W'(i + 1);
        e0 = n_errp; f0 = n_fd;
        cfg(4, 48'h1_0000, 48'h0);
        chk("cfg_busy", busy, 1'b1);
        chk("cfg_ys", core_ys, 48'h1_0000);
        chk("cfg_yb", core_yb, 48'h0);
        chk("cfg_N", core_N, 4);
        fill(4, -1, 1'b1, 1'b0);
        passes(4, 5, 1'b0, 0);
        chk("f1_err_cnt", n_errp - e0, 0);
        chk("f1_fd_cnt", n_fd - f0, 1);

        // illegal configs
        e0 = n_errp;
        cfg(0, 48'h5, 48'h6);
        chk("cfg0_err", err, 1'b1);
        chk("cfg0_busy", busy, 1'b0);
        cfg(300, 48'h5, 48'h6);
        chk("cfg300_err", err, 1'b1);
        chk("cfg300_busy", busy, 1'b0);
        chk("cfg300_ready", s_ready, 1'b0);
        chk("cfg_bad_N", core_N, 4);
        chk("cfg_bad_ys", core_ys, 48'h1_0000);
        tick();
        chk("cfg_bad_err_cnt", n_errp - e0, 2);

        // early s_last on beat 5 of 8
        for (int i = 0; i < 8; i++) dat[i] = 48'h8000_0000_0000 | W'(i * 17 + 3);
        e0 = n_errp;
        cfg(8, 48'hFFFF_FFFF_0000, 48'h0000_0001_2345);
        fill(8, 4, 1'b1, 1'b0);
        chk("early_last_errs", n_errp - e0, 1);
        passes(8, 2, 1'b0, 0);

        // gappy handshake plus a stray core_done code in pass 1
        for (int i = 0; i < 5; i++) dat[i] = W'(48'hA5A5_0000_0000 + W'(i * 4099));
        e0 = n_errp;
        cfg(5, 48'h2_0000, 48'h7);
        fill(5, -1, 1'b1, 1'b1);
        passes(5, 3, 1'b1, 0);
        chk("toggle_err_cnt", n_errp - e0, 0);

        // abort mid-stream of pass 2
        for (int i = 0; i < 6; i++) dat[i] = W'(100 + i);
        f0 = n_fd;
        cfg(6, 48'h3, 48'h4);
        fill(6, -1, 1'b1, 1'b0);
        passes(6, 1, 1'b0, 2);
        #2 rst = 1'b1;
        #1;
        chk("abort_in", core_in, 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_N", core_N, 0);
        chk("abort_start", core_start, 2'b00);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_fd", n_fd - f0, 0);
        chk("abort_ready", s_ready, 1'b0);

        // full-depth frame
        for (int i = 0; i < NM; i++) dat[i] = 48'hC000_0000_0000 | W'(i * 977 + 5);
        e0 = n_errp; f0 = n_fd;
        cfg(NM, 48'h1234, 48'h5678);
        fill(NM, -1, 1'b1, 1'b0);
        passes(NM, 4, 1'b0, 0);
        chk("full_err_cnt", n_errp - e0, 0);
        chk("full_fd_cnt", n_fd - f0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
